ps2_host_tx: RTL

Host-to-device PS/2 transmitter: it sends one command byte, such as LED set (0xED) or reset (0xFF), from the host to the keyboard over the shared open-drain clock and data lines. The block runs the full host request sequence: clock inhibit, start request, data bits driven on device clock falling edges, odd parity, stop bit, and device ACK sampling. It sits beside the PS/2 receive path on the same pins. It drives `busy` so the receive path can ignore line activity caused by a host transmission.

---
 rtl/ps2_host_tx.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with inhibit, framing and ACK.
// Optional watchdog: define PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack,
  output logic       tx_err
);

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                           INHIBIT_CYCLES : TIMEOUT_CYCLES;
`else
  localparam int CNT_MAX = INHIBIT_CYCLES + 0 * TIMEOUT_CYCLES;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    START,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      sh_q, sh_d;
  logic            par_q, par_d;
  logic [2:0]      bit_q, bit_d;
  logic            ack_q, ack_d;
`ifdef PS2_HOST_TX_TIMEOUT_EN
  logic            err_q, err_d;
`endif

  logic clk_s1_q, clk_s2_q, clk_h_q;
  logic dat_s1_q, dat_s2_q;
  logic fall;

  // Pin synchronisers and clock history; idle lines read as high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_h_q  <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      clk_h_q  <= clk_s2_q;
      dat_s1_q <= ps2_data_in;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fall = clk_h_q & ~clk_s2_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      ack_q   <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      ack_q   <= ack_d;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state: request sequence, bit shifting on device clock falls
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    bit_d   = bit_q;
    ack_d   = ack_q;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = INHIBIT;
          cnt_d   = '0;
          sh_d    = tx_data;
          par_d   = ~^tx_data;
          ack_d   = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      START: begin
        if (fall) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (fall) begin
          if (bit_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            sh_d  = {1'b0, sh_q[7:1]};
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (fall) state_d = STOP;
      end
      STOP: begin
        if (fall) state_d = ACK;
      end
      // The 11th fall lands in STOP; the device holds data
      // low through that clock-low phase, so sample it here.
      ACK: begin
        ack_d   = ~dat_s2_q;
        state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (clk_s2_q & dat_s2_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
    if (state_q inside {START, DATA, PARITY,
                        STOP, ACK, WAIT_IDLE}) begin
      if (fall) begin
        cnt_d = '0;
      end else if (cnt_q == TMO_LAST) begin
        state_d = DONE;
        cnt_d   = '0;
        ack_d   = 1'b0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  // Open-drain enables decoded from registered state
  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    unique case (state_q)
      INHIBIT: ps2_clk_oe  = 1'b1;
      START:   ps2_data_oe = 1'b1;
      DATA:    ps2_data_oe = ~sh_q[0];
      PARITY:  ps2_data_oe = ~par_q;
      default: ;
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign tx_done  = (state_q == DONE);
  assign tx_ack   = tx_done & ack_q;
`ifdef PS2_HOST_TX_TIMEOUT_EN
  assign tx_err   = tx_done & err_q;
`else
  assign tx_err   = 1'b0;
`endif

endmodule
